// File: rtl/uart_pkg.sv
// Shared UART definitions: baud timing and receiver FSM encodings.
// The transmitter and receiver both import this so their bit periods always match.
package uart_pkg;

    // CLK_100M cycles per bit (~144.1 kbaud)
    localparam int unsigned P_BIT_CNT  = 694;
    // Cycles from detected start edge to the mid-start-bit sample
    localparam int unsigned P_HALF_CNT = 347;
    // Bit-period counter width; must hold P_BIT_CNT-1
    localparam int unsigned P_CNT_W    = 10;

    // One-hot receiver states
    typedef enum logic [3:0] {
        P_IDLE      = 4'b0001,
        P_START_BIT = 4'b0010,
        P_DATA_BITS = 4'b0100,
        P_STOP_BIT  = 4'b1000
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus an edge-history flop.
// All flops reset to 1 (idle line level) so reset never fakes a start edge on an idle line.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_start_edge
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Synchronize the line and keep one cycle of history for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_rx_s       = r_sync;
    // Falling edge only: a line held low cannot retrigger
    assign o_start_edge = r_hist & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing (extra stop bits tolerated), LSB first, mid-bit sampling.
// Presents each good byte with a one-cycle valid strobe and flags bad stop bits.
module uart_rx
    import uart_pkg::*;
(
    input  logic       CLK_100M,
    input  logic       SYS_RST,
    input  logic       UART_IN,
    output logic [7:0] UART_DEC_DATA,
    output logic       UART_DEC_VALID,
    output logic       UART_DEC_FRAME_ERR,
    output logic       UART_DEC_BUSY
);

    localparam logic [P_CNT_W-1:0] L_HALF_TERM = P_CNT_W'(P_HALF_CNT - 1);
    localparam logic [P_CNT_W-1:0] L_BIT_TERM  = P_CNT_W'(P_BIT_CNT - 1);

    logic w_rx_s;
    logic w_start_edge;

    uart_rx_state_e     r_state;
    uart_rx_state_e     w_state_next;
    logic [P_CNT_W-1:0] r_cnt;
    logic [P_CNT_W-1:0] w_cnt_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic [7:0]         r_data;
    logic [7:0]         w_data_next;
    logic               r_valid;
    logic               w_valid_next;
    logic               r_frame_err;
    logic               w_frame_err_next;
    logic               r_busy;

    uart_rx_sync u_sync (
        .i_clk        (CLK_100M),
        .i_rst        (SYS_RST),
        .i_rx         (UART_IN),
        .o_rx_s       (w_rx_s),
        .o_start_edge (w_start_edge)
    );

    // Next-state, counter, shift register and strobe logic
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_valid_next     = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            P_IDLE: begin
                w_cnt_next = '0;
                if (w_start_edge) begin
                    w_state_next = P_START_BIT;
                end
            end
            P_START_BIT: begin
                if (r_cnt == L_HALF_TERM) begin
                    w_cnt_next = '0;
                    if (!w_rx_s) begin
                        w_state_next   = P_DATA_BITS;
                        w_bit_idx_next = '0;
                    end else begin
                        // Line back high at mid-start: glitch, drop it silently
                        w_state_next = P_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + P_CNT_W'(1);
                end
            end
            P_DATA_BITS: begin
                if (r_cnt == L_BIT_TERM) begin
                    w_cnt_next     = '0;
                    // Right shift: first (LSB) bit ends up in bit 0 after eight samples
                    w_shift_next   = {w_rx_s, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = P_STOP_BIT;
                    end
                end else begin
                    w_cnt_next = r_cnt + P_CNT_W'(1);
                end
            end
            P_STOP_BIT: begin
                if (r_cnt == L_BIT_TERM) begin
                    // Leave at mid-stop so a back-to-back start edge is caught in idle
                    w_cnt_next   = '0;
                    w_state_next = P_IDLE;
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + P_CNT_W'(1);
                end
            end
            default: begin
                w_state_next   = P_IDLE;
                w_cnt_next     = '0;
                w_bit_idx_next = '0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge CLK_100M) begin
        if (SYS_RST) begin
            r_state     <= P_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_busy      <= (r_state != P_IDLE);
        end
    end

    assign UART_DEC_DATA      = r_data;
    assign UART_DEC_VALID     = r_valid;
    assign UART_DEC_FRAME_ERR = r_frame_err;
    assign UART_DEC_BUSY      = r_busy;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the mating end of the existing UART transmitter: 8 data bits, LSB first, no parity, 1 start bit, at least 1 stop bit. It checks one stop bit and accepts the 2-stop-bit frames the transmitter sends.
Samples an asynchronous serial line on CLK_100M, recovers each byte, and presents it with a one-cycle valid strobe to the downstream decoder/command logic.
Flags framing errors and rejects start-bit glitches.

Parameters:
P_BIT_CNT, 694, CLK_100M cycles per bit (matches the transmitter bit period, approx. 144.1 kbaud)
P_HALF_CNT, 347, cycles from detected start edge to mid-start-bit sample
P_CNT_W, 10, bit-period counter width; must hold P_BIT_CNT-1

Ports:
CLK_100M  input  1  system clock, 100 MHz
SYS_RST  input  1  reset, synchronous, active-high
UART_IN  input  1  asynchronous serial line, idle high
UART_DEC_DATA  output  8  last correctly received byte
UART_DEC_VALID  output  1  one-cycle strobe; UART_DEC_DATA is new this cycle
UART_DEC_FRAME_ERR  output  1  one-cycle strobe; stop bit sampled low
UART_DEC_BUSY  output  1  high whenever the FSM is not in P_IDLE

Behaviour:
- Clocking and reset: one clock, CLK_100M. Reset is synchronous and active-high on SYS_RST; all state changes on the rising CLK_100M edge.
- Reset values:
  - Synchronizer flops and edge-history flop: 1.
  - UART_DEC_DATA: 8'h00.
  - UART_DEC_VALID, UART_DEC_FRAME_ERR, UART_DEC_BUSY: 0.
  - FSM: P_IDLE. Counter, bit index and shift register: 0.
- Input conditioning: UART_IN passes through a 2-flop synchronizer (rx_s). A third flop holds the previous value (rx_d). The start edge is rx_d==1 && rx_s==0.
- FSM, one-hot, 4 bits:
  - P_IDLE: clear the counter. On the start edge, go to P_START_BIT. A line held low never retriggers, because an edge is required.
  - P_START_BIT: count 0..P_HALF_CNT-1. At the terminal count, sample rx_s.
    - rx_s==0: go to P_DATA_BITS, counter cleared.
    - rx_s==1: false start, return to P_IDLE with no strobe.
  - P_DATA_BITS: count 0..P_BIT_CNT-1. At each terminal count:
    - shift rx_s into the MSB of an 8-bit shift register (right shift, so LSB-first arrival lands correctly);
    - increment the bit index 0..7.
    - After the 8th sample (index==7), go to P_STOP_BIT.
  - P_STOP_BIT: count 0..P_BIT_CNT-1. At the terminal count, sample rx_s and return to P_IDLE in the same edge.
    - rx_s==1: UART_DEC_DATA <= shift register; UART_DEC_VALID=1 for exactly one cycle.
    - rx_s==0: UART_DEC_FRAME_ERR=1 for exactly one cycle; UART_DEC_DATA keeps its old value.
  - Illegal or unused state encodings recover to P_IDLE on the next clock.
- Timing:
  - The return to P_IDLE at mid-stop-bit allows back-to-back frames with 1 stop bit. The next start edge is detected while in P_IDLE.
  - Latency, UART_IN falling edge to VALID: 2 (sync) + 1 (edge) + P_HALF_CNT + 9*P_BIT_CNT = 6596 cycles, ±1 for input phase.
  - Samples land at the mid-bit point; tolerance is about ±4.5% total baud mismatch.
- UART_DEC_BUSY = (state != P_IDLE), registered, so it follows the state by one cycle.
- VALID and FRAME_ERR are mutually exclusive and never asserted in consecutive cycles.
- Reset mid-frame: returns to P_IDLE immediately and discards the partial byte. The remainder of the interrupted frame may be seen as new edges; any resulting errors are acceptable. The next clean frame must be received correctly.
- Counter arithmetic: unsigned, P_CNT_W bits; compare with ==; no wrap past terminal count.

Decomposition:
- Shared package uart_pkg, containing:
  - state encodings P_IDLE=4'b0001, P_START_BIT=4'b0010, P_DATA_BITS=4'b0100, P_STOP_BIT=4'b1000;
  - P_BIT_CNT and P_HALF_CNT. The transmitter and receiver both use this package so baud always matches.
- One sub-module, uart_rx_sync: 2-flop synchronizer plus edge-history flop.
  - Outputs: rx_s and start_edge.
  - Reset value 1 on all flops.
- FSM, counters and output registers live in uart_rx.

Test Plan:
- Frame 0xA5 at P_BIT_CNT=694, 2 stop bits -> exactly one VALID pulse with DATA=8'hA5, FRAME_ERR never high, VALID at 6596±1 cycles after the falling edge, BUSY high from about 3 cycles after the edge until after VALID.
- Back-to-back frames 0x00, 0xFF, 0x3C with 1 stop bit and no idle gap -> three VALID pulses with DATA 00, FF, 3C, spaced 10*694 cycles apart.
- 100-cycle low glitch on an idle line -> no VALID, no FRAME_ERR; BUSY returns low about 350 cycles after the glitch; a following frame 0x5A is received correctly.
- Frame 0x81 with stop bit driven low, then line held low for 5000 cycles, then released high -> one FRAME_ERR pulse, no VALID, DATA unchanged, no retrigger while low; next frame 0x7E is received OK.
- SYS_RST asserted for 1 cycle during data bit 3 of a frame -> the next cycle shows DATA=00, BUSY=0, both strobes 0; a subsequent clean 0xC3 frame gives DATA=C3.
- Loopback of the transmitter output into UART_IN over 256 random bytes -> every byte received in order, zero FRAME_ERR.
